load_store_unit: RTL and testbench

//   Sequencer between the execute stage and mem_interface. Accepts one load/store request at a time

---
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequencer between the execute stage and mem_interface. Takes one load/store
//   request at a time, holds its operands on the mem_* outputs, drives rd/wr
//   until the bus grants the access, and returns data or a fault on the
//   response port.
//   Optional feature: define LSU_TIMEOUT_EN to bound the wait for a bus grant
//   (fault cause 2 after TIMEOUT_CYCLES ungranted ISSUE cycles).
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_fault,
  output logic [1:0]            resp_cause,
  input  logic                  bus_available,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [2:0]            mem_sign_size,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_malign,
  input  logic                  mem_complete_read,
  input  logic                  mem_complete_write
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_MALIGN = 2'd1;

  state_t                r_state;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_req_ready;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic                  r_resp_valid;
  logic                  r_resp_fault;
  logic [1:0]            r_resp_cause;
  logic [DATA_WIDTH-1:0] r_resp_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;

  // The ungranted cycle that would bring the count to TIMEOUT_CYCLES is the last one waited
  assign w_timeout = (r_wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`else
  // Without the timeout the limit has no function; keep it referenced for lint
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // The memory-side operands always come from the latched request, so they stay
  // stable from acceptance until the LSU is idle again.
  assign mem_address   = r_addr;
  assign mem_sign_size = r_funct3;
  assign mem_wdata     = r_wdata;
  assign mem_rd        = r_mem_rd;
  assign mem_wr        = r_mem_wr;
  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_tag      = r_tag;
  assign resp_fault    = r_resp_fault;
  assign resp_cause    = r_resp_cause;

  // Transaction sequencer: state plus every registered output, one process
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the asynchronous reset clears every register here, including the
    // latched request fields, so rd/wr drop the moment rst rises.
    if (rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag        <= '0;
      r_req_ready  <= 1'b1;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_cause <= CAUSE_NONE;
      r_resp_data  <= '0;
`ifdef LSU_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the state as it was at the start of the cycle.
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_tag       <= req_tag;
            r_req_ready <= 1'b0;
            r_mem_rd    <= !req_write;
            r_mem_wr    <= req_write;
`ifdef LSU_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (mem_malign) begin
            // Misalignment wins over a grant; the access never reaches the bus
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
            r_resp_cause <= CAUSE_MALIGN;
            r_resp_data  <= '0;
            r_state      <= S_RESP;
          end else if (bus_available && r_write) begin
            // Stores complete in the grant cycle
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
            r_resp_data  <= '0;
            r_state      <= S_RESP;
          end else if (bus_available) begin
            // Drop rd immediately so the granted read is not issued twice
            r_mem_rd <= 1'b0;
            r_state  <= S_WAIT_RD;
          end
`ifdef LSU_TIMEOUT_EN
          else if (w_timeout) begin
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
            r_resp_cause <= CAUSE_TIMEOUT;
            r_resp_data  <= '0;
            r_state      <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_WAIT_RD: begin
          if (mem_complete_read) begin
            r_resp_data  <= mem_rdata;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
            r_resp_data  <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A granted read must complete in the cycle after the grant
  a_read_completes : assert property (@(posedge clk) disable iff (rst)
    (r_state == S_WAIT_RD) |-> mem_complete_read);

  // A granted, aligned store must be acknowledged in its grant cycle
  a_write_completes : assert property (@(posedge clk) disable iff (rst)
    (r_state == S_ISSUE && r_write && bus_available && !mem_malign) |-> mem_complete_write);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Randomized and directed stimulus for load_store_unit against a
//   transaction-level reference model (byte-array memory, alignment and latency
//   rules). A small stand-in for mem_interface provides malign, completions and
//   extended read data from its own memory. Build with +define+LSU_TIMEOUT_EN to
//   exercise the timeout path (TIMEOUT_CYCLES = 4 here).
module tb_load_store_unit;

  localparam int TMO = 4;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  tag;
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
    int          busy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        bus_available;
  logic [31:0] mem_address;
  logic [2:0]  mem_sign_size;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_malign, mem_complete_read, mem_complete_write;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem[256];
  logic [7:0]  bus_mem[256];
  logic [31:0] last_data;
  logic [4:0]  last_tag;
  logic        last_fault;
  logic [1:0]  last_cause;

  // bus stand-in state
  bit          rd_pending;
  logic [31:0] rd_addr;
  logic [2:0]  rd_f3;

  load_store_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_fault(resp_fault), .resp_cause(resp_cause),
    .bus_available(bus_available), .mem_address(mem_address), .mem_sign_size(mem_sign_size),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_malign(mem_malign), .mem_complete_read(mem_complete_read),
    .mem_complete_write(mem_complete_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
  endfunction

  assign mem_malign         = misaligned(mem_sign_size, mem_address);
  assign mem_complete_write = mem_wr && bus_available && !mem_malign;

  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return f3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // which: 0 = reference model memory, 1 = bus stand-in memory
  function automatic logic [31:0] mem_raw(input bit which, input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] idx;
      idx = a[7:0] + 8'(i);
      r[8*i +: 8] = which ? bus_mem[idx] : ref_mem[idx];
    end
    return r;
  endfunction

  function automatic void mem_store(input bit which, input logic [31:0] a,
                                    input logic [31:0] d, input logic [2:0] f3);
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      logic [7:0] idx;
      idx = a[7:0] + 8'(i);
      if (which) bus_mem[idx] = d[8*i +: 8];
      else       ref_mem[idx] = d[8*i +: 8];
    end
  endfunction

  // Reference model: the outcome and timing of one whole transaction
  function automatic exp_t predict(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [4:0] tg, input int stall);
    exp_t e;
    bit   tmo;
    e.w = w; e.f3 = f3; e.addr = a; e.wd = wd; e.tag = tg;
    e.data = 32'h0; e.fault = 1'b0; e.cause = 2'd0;
`ifdef LSU_TIMEOUT_EN
    tmo = (stall >= TMO);
`else
    tmo = 1'b0;
`endif
    if (misaligned(f3, a)) begin
      e.fault = 1'b1; e.cause = 2'd1; e.lat = 2; e.busy = 1;
    end else if (tmo) begin
      e.fault = 1'b1; e.cause = 2'd2; e.lat = 1 + TMO; e.busy = TMO;
    end else begin
      e.busy = stall + 1;
      if (w) begin
        mem_store(1'b0, a, wd, f3);
        e.lat = stall + 2;
      end else begin
        e.data = load_ext(mem_raw(1'b0, a), f3);
        e.lat  = stall + 3;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: bus stand-in reacts to the cycle's grant, then the edge.
  // Entered and left at posedge+2, where all bench inputs are set.
  task automatic cycle();
    #1;
    if (mem_rd && bus_available && !mem_malign) begin
      rd_pending = 1'b1;
      rd_addr    = mem_address;
      rd_f3      = mem_sign_size;
    end
    if (mem_complete_write) mem_store(1'b1, mem_address, mem_wdata, mem_sign_size);
    @(posedge clk);
    #2;
    mem_complete_read = rd_pending;
    mem_rdata         = rd_pending ? load_ext(mem_raw(1'b1, rd_addr), rd_f3) : $urandom();
    rd_pending        = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) cycle();
    check("req_ready_wait", req_ready, 1);
  endtask

  // Drive bus grant and response acceptance until the response is taken
  task automatic serve(input int stall, input int rdy_delay, output bit done);
    int st;
    int rd;
    st   = stall;
    rd   = rdy_delay;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      if (mem_rd || mem_wr) begin
        bus_available = (st == 0);
        if (st > 0) st--;
      end else begin
        bus_available = 1'($urandom_range(0, 1));
      end
      if (resp_valid) begin
        if (rd > 0) begin resp_ready = 1'b0; rd--; end
        else begin resp_ready = 1'b1; done = 1'b1; end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    resp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] tg, input int stall,
                        input int rdy, input bit chain, output exp_t e);
    bit   done;
    exp_t e2;
    wait_ready();
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_tag = tg;
    req_valid = 1'b1;
    e = predict(w, f3, a, wd, tg, stall);
    exp_q.push_back(e);
    if (chain) begin
      e2 = predict(w, f3, a, wd, tg, stall);
      exp_q.push_back(e2);
    end
    cycle();
    if (!chain) req_valid = 1'b0;
    serve(stall, rdy, done);
    check("serve_bound", done, 1);
    if (chain) begin
      // The held request must be taken in the first IDLE cycle
      check("chain_req_ready", req_ready, 1);
      cycle();
      req_valid = 1'b0;
      serve(stall, 0, done);
      check("serve_bound_chain", done, 1);
    end
  endtask

  // Compare process: checks DUT outputs against the model every cycle
  initial begin
    int   cyc;
    int   acc_cyc;
    int   busy;
    bit   prev_valid;
    bit   prev_ready;
    exp_t f;
    logic [31:0] s_data;
    logic [4:0]  s_tag;
    logic        s_fault;
    logic [1:0]  s_cause;
    cyc = 0; acc_cyc = 0; busy = 0; prev_valid = 0; prev_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        prev_ready = 0;
        continue;
      end
      cyc++;
      if ((mem_rd || mem_wr) && exp_q.size() > 0) begin
        f = exp_q[0];
        busy++;
        check("mem_address", mem_address, f.addr);
        check("mem_sign_size", mem_sign_size, f.f3);
        check("mem_wdata", mem_wdata, f.wd);
        check("mem_rd", mem_rd, !f.w);
        check("mem_wr", mem_wr, f.w);
      end
      if (resp_valid) begin
        check("req_ready_in_resp", req_ready, 0);
        if (!prev_valid) begin
          check("resp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() > 0) check("resp_latency", cyc - acc_cyc, exp_q[0].lat);
        end else if (!prev_ready) begin
          check("hold_data", resp_data, s_data);
          check("hold_tag", resp_tag, s_tag);
          check("hold_fault", resp_fault, s_fault);
          check("hold_cause", resp_cause, s_cause);
        end
        s_data = resp_data; s_tag = resp_tag; s_fault = resp_fault; s_cause = resp_cause;
        if (resp_ready && exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("resp_data", resp_data, f.data);
          check("resp_tag", resp_tag, f.tag);
          check("resp_fault", resp_fault, f.fault);
          check("resp_cause", resp_cause, f.cause);
          check("busy_cycles", busy, f.busy);
          last_data = resp_data; last_tag = resp_tag;
          last_fault = resp_fault; last_cause = resp_cause;
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        busy    = 0;
      end
      prev_valid = resp_valid;
      prev_ready = resp_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    exp_t e;
    logic [2:0] lf3[5];
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 7 + 3);
      bus_mem[i] = 8'(i * 7 + 3);
    end
    // Word at 0x100 (index 0) = 0xDEADBEEF
    mem_store(1'b0, 32'h100, 32'hDEADBEEF, 3'b010);
    mem_store(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);

    rst = 1'b1;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_tag = 0;
    resp_ready = 0; bus_available = 0; mem_rdata = 0; mem_complete_read = 0;
    rd_pending = 0; rd_addr = 0; rd_f3 = 0;
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_resp_data", resp_data, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // LW 0x100, bus free
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 0, 0, 1'b0, e);
    check("pin_lw_lat", e.lat, 3);
    check("lw_data", last_data, 32'hDEADBEEF);
    check("lw_fault", last_fault, 0);
    check("lw_tag", last_tag, 5'd1);

    // SB 0x103 <- 0x80, then LB / LBU
    do_txn(1'b1, 3'b000, 32'h103, 32'hAAAA_AA80, 5'd2, 0, 0, 1'b0, e);
    check("pin_sb_lat", e.lat, 2);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 0, 0, 1'b0, e);
    check("lb_data", last_data, 32'hFFFFFF80);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 0, 0, 1'b0, e);
    check("lbu_data", last_data, 32'h00000080);

    // SH 0x102 <- 0x1234 with 4 ungranted cycles (no timeout at TMO=4 only if stall<4)
`ifdef LSU_TIMEOUT_EN
    do_txn(1'b1, 3'b001, 32'h102, 32'h0000_1234, 5'd5, 3, 0, 1'b0, e);
    check("pin_sh_busy", e.busy, 4);
`else
    do_txn(1'b1, 3'b001, 32'h102, 32'h0000_1234, 5'd5, 4, 0, 1'b0, e);
    check("pin_sh_busy", e.busy, 5);
    check("pin_sh_lat", e.lat, 6);
`endif
    check("sh_fault", last_fault, 0);
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd6, 0, 0, 1'b0, e);
    check("lw_after_sh", last_data, 32'h1234BEEF);

    // LW 0x101: misaligned, bus granted immediately
    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 5'd7, 0, 0, 1'b0, e);
    check("malign_fault", last_fault, 1);
    check("malign_cause", last_cause, 2'd1);
    check("malign_data", last_data, 32'h0);

    // Back-pressure with a held request behind it
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd8, 1, 3, 1'b1, e);
    check("chain_data", last_data, 32'h1234BEEF);

    // Long bus stall
`ifdef LSU_TIMEOUT_EN
    do_txn(1'b0, 3'b001, 32'h104, 32'h0, 5'd9, 10, 0, 1'b0, e);
    check("tmo_fault", last_fault, 1);
    check("tmo_cause", last_cause, 2'd2);
    check("pin_tmo_busy", e.busy, TMO);
`else
    do_txn(1'b0, 3'b001, 32'h104, 32'h0, 5'd9, 20, 0, 1'b0, e);
    check("long_stall_fault", last_fault, 0);
    check("pin_long_lat", e.lat, 23);
`endif

    // Reset pulse while a granted read is in WAIT_RD
    wait_ready();
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_tag = 5'd10;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    bus_available = 1'b1;
    cycle();
    rst = 1'b1;
    #1;
    check("rstmid_req_ready", req_ready, 1);
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_mem_rd", mem_rd, 0);
    mem_complete_read = 1'b0;
    rd_pending = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd11, 0, 0, 1'b0, e);
    check("after_rst_lw", last_data, 32'h1234BEEF);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic       w;
      logic [2:0] f3;
      w  = 1'($urandom_range(0, 1));
      f3 = w ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      do_txn(w, f3, 32'h1000 + $urandom_range(0, 63), $urandom(), 5'($urandom()),
             $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 9) == 0), e);
    end

    repeat (3) cycle();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
